// File: rtl/i2c_scl_gen_stretch.sv
// i2c_scl_gen_stretch
// I2C master SCL / data-phase timing generator. One SCL period is four
// quarters of DIVIDER clk cycles each; quarter 2 (SCL high) is held while a
// slave stretches SCL low.
// Build option: define I2C_STRETCH_TIMEOUT_EN to bound each stretch to
// TIMEOUT_CYC held cycles and raise a sticky timeout flag when it expires.

module i2c_scl_gen_stretch #(
    parameter int DIVIDER     = 250,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic stretch_en,
    input  logic scl_in,
    input  logic timeout_clr,
    output logic scl_clk,
    output logic data_clk,
    output logic high_window,
    output logic stretching,
    output logic data_rise,
    output logic scl_rise,
    output logic scl_fall,
    output logic timeout
);

    localparam int CBITS = $clog2(4*DIVIDER);

    // Quarter boundaries expressed in the counter's own width.
    localparam logic [CBITS-1:0] Q1_START = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] Q2_START = CBITS'(2*DIVIDER);
    localparam logic [CBITS-1:0] Q3_START = CBITS'(3*DIVIDER);
    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4*DIVIDER-1);

    logic [CBITS-1:0]       cnt;
    logic [CBITS-1:0]       cnt_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   scl_sync;
    logic                   hold;
    logic                   stretch_release;

    assign scl_sync = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous bus line into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // The bus idles high, so the chain starts high to avoid a false stretch.
            sync_q <= '1;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours.
            sync_q <= {sync_q[SYNC_STAGES-2:0], scl_in};
        end
    end

    // Next counter value: hold at the start of the high quarter while stretched.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        hold     = 1'b0;
        cnt_next = '0;
        if (ena) begin
            hold = (cnt == Q2_START) && stretch_en && !scl_sync && !stretch_release;
            if (hold)
                cnt_next = cnt;
            else if (cnt == CNT_LAST)
                cnt_next = '0;
            else
                cnt_next = cnt + 1'b1;
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam int TBITS = $clog2(TIMEOUT_CYC+1);

    logic [TBITS-1:0] stretch_cnt;
    logic             timeout_set;

    // Releasing happens on the edge after TIMEOUT_CYC consecutive hold cycles.
    assign stretch_release = (stretch_cnt >= TBITS'(TIMEOUT_CYC));
    assign timeout_set     = ena && (cnt == Q2_START) && stretch_en && !scl_sync
                             && stretch_release;

    // Count consecutive hold cycles; any non-hold cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stretch_cnt <= '0;
        else if (hold)
            stretch_cnt <= stretch_cnt + 1'b1;
        else
            stretch_cnt <= '0;
    end

    // Sticky timeout flag; a clear request beats a set on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout <= 1'b0;
        else if (timeout_clr)
            timeout <= 1'b0;
        else if (timeout_set)
            timeout <= 1'b1;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    logic          unused_timeout_clr;

    assign unused_timeout_clr = timeout_clr;
    assign stretch_release    = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Load the counter and decode all outputs from cnt_next on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            scl_clk     <= 1'b1;
            data_clk    <= 1'b0;
            high_window <= 1'b0;
            stretching  <= 1'b0;
            data_rise   <= 1'b0;
            scl_rise    <= 1'b0;
            scl_fall    <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            scl_clk     <= !ena || (cnt_next >= Q2_START);
            data_clk    <= ena && (cnt_next >= Q1_START) && (cnt_next < Q3_START);
            high_window <= ena && (cnt_next >= Q2_START) && (cnt_next < Q3_START);
            stretching  <= hold;
            data_rise   <= ena && (cnt_next == Q1_START) && (cnt != Q1_START);
            scl_rise    <= ena && (cnt_next == Q2_START) && (cnt != Q2_START);
            scl_fall    <= ena && (cnt_next == '0) && (cnt == CNT_LAST);
        end
    end

    // A hold can only happen at the start of the high quarter.
    a_stretch_in_high_window : assert property (
        @(posedge clk) disable iff (rst) stretching |-> high_window
    );

endmodule

// File: tb/tb_i2c_scl_gen_stretch.sv
// tb_i2c_scl_gen_stretch
// Directed bench for i2c_scl_gen_stretch with DIVIDER=4, SYNC_STAGES=2,
// TIMEOUT_CYC=20. Per-cycle vectors carry the expected counter value and
// strobes; level outputs are decoded from the expected counter.

module tb_i2c_scl_gen_stretch;

    localparam int DIVIDER     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 20;

    logic clk;
    logic rst;
    logic ena;
    logic stretch_en;
    logic scl_drv;
    logic loop_mode;
    logic timeout_clr;
    logic scl_in;
    logic scl_clk;
    logic data_clk;
    logic high_window;
    logic stretching;
    logic data_rise;
    logic scl_rise;
    logic scl_fall;
    logic timeout;

    // Loopback models a bus with no slave: the line follows the master.
    assign scl_in = loop_mode ? scl_clk : scl_drv;

    i2c_scl_gen_stretch #(
        .DIVIDER     (DIVIDER),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .stretch_en  (stretch_en),
        .scl_in      (scl_in),
        .timeout_clr (timeout_clr),
        .scl_clk     (scl_clk),
        .data_clk    (data_clk),
        .high_window (high_window),
        .stretching  (stretching),
        .data_rise   (data_rise),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  ena;
        logic  sen;
        logic  scl;
        logic  clr;
        int    cnt;   // expected counter after the edge; -1 means idle/reset
        logic  str;
        logic  dr;
        logic  sr;
        logic  sf;
        logic  to;
        string tag;
    } vec_t;

    vec_t  tbl[$];
    int    checks = 0;
    int    errors = 0;
    int    m_cnt  = 0;
    logic  m_to   = 1'b0;
    string cur_tag = "none";

    localparam logic [7:0] IDLE_BITS = 8'b1000_0000;

    function automatic logic [7:0] observed();
        return {scl_clk, data_clk, high_window, stretching,
                data_rise, scl_rise, scl_fall, timeout};
    endfunction

    function automatic logic [7:0] expect_bits(vec_t v);
        logic s, d, h;
        if (v.cnt < 0) begin
            s = 1'b1; d = 1'b0; h = 1'b0;
        end else begin
            s = (v.cnt >= 2*DIVIDER);
            d = (v.cnt >= DIVIDER) && (v.cnt < 3*DIVIDER);
            h = (v.cnt >= 2*DIVIDER) && (v.cnt < 3*DIVIDER);
        end
        return {s, d, h, v.str, v.dr, v.sr, v.sf, v.to};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic sen, input logic scl, input logic clr,
                        input int c, input logic str, input logic dr, input logic sr,
                        input logic sf);
        vec_t v;
        v.ena = e; v.sen = sen; v.scl = scl; v.clr = clr;
        v.cnt = c; v.str = str; v.dr = dr; v.sr = sr; v.sf = sf;
        v.to  = m_to; v.tag = cur_tag;
        tbl.push_back(v);
    endtask

    // Free-running cycles; the caller guarantees no hold can occur.
    task automatic step_free(input int n, input logic sen, input logic scl, input logic clr);
        for (int i = 0; i < n; i++) begin
            int nxt;
            nxt = (m_cnt == 4*DIVIDER-1) ? 0 : m_cnt + 1;
            push(1'b1, sen, scl, clr, nxt, 1'b0,
                 nxt == DIVIDER, nxt == 2*DIVIDER, nxt == 0);
            m_cnt = nxt;
        end
    endtask

    // Cycles held at the start of the high quarter.
    task automatic step_hold(input int n, input logic scl, input logic clr);
        for (int i = 0; i < n; i++)
            push(1'b1, 1'b1, scl, clr, 2*DIVIDER, 1'b1, 1'b0, 1'b0, 1'b0);
        m_cnt = 2*DIVIDER;
    endtask

    task automatic step_idle(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_cnt = 0;
    endtask

    // Apply each vector just after an edge, compare one cycle later.
    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            ena         = tbl[i].ena;
            stretch_en  = tbl[i].sen;
            scl_drv     = tbl[i].scl;
            timeout_clr = tbl[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tbl[i].tag, i), {24'd0, observed()},
                  {24'd0, expect_bits(tbl[i])});
        end
        tbl.delete();
    endtask

    initial begin
        int   n;
        int   n_str;
        int   n_rise;
        logic ok;

        rst = 1'b0; ena = 1'b0; stretch_en = 1'b1; scl_drv = 1'b1;
        loop_mode = 1'b0; timeout_clr = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_state", {24'd0, observed()}, {24'd0, IDLE_BITS});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        cur_tag = "idle";
        step_idle(2);
        cur_tag = "free_run";
        step_free(32, 1'b1, 1'b1, 1'b0);
        cur_tag = "stretch_off";
        step_free(16, 1'b0, 1'b0, 1'b0);

        // Slave pulls SCL low before the rise; two extra held cycles follow
        // its release while the synchroniser catches up.
        cur_tag = "stretch_10";
        step_free(4, 1'b1, 1'b1, 1'b0);
        step_free(4, 1'b1, 1'b0, 1'b0);
        step_hold(10, 1'b0, 1'b0);
        step_hold(2, 1'b1, 1'b0);
        step_free(8, 1'b1, 1'b1, 1'b0);

`ifdef I2C_STRETCH_TIMEOUT_EN
        cur_tag = "stretch_timeout";
        step_free(4, 1'b1, 1'b1, 1'b0);
        step_free(4, 1'b1, 1'b0, 1'b0);
        step_hold(TIMEOUT_CYC, 1'b0, 1'b0);
        m_to = 1'b1;
        step_free(1, 1'b1, 1'b0, 1'b0);   // released to 9, flag set
        step_free(7, 1'b1, 1'b0, 1'b0);
        step_free(8, 1'b1, 1'b0, 1'b0);
        step_hold(TIMEOUT_CYC, 1'b0, 1'b0);
        step_free(1, 1'b1, 1'b0, 1'b0);   // second release, flag still set
        m_to = 1'b0;
        step_free(1, 1'b1, 1'b0, 1'b1);   // clear pulse
        step_free(6, 1'b1, 1'b0, 1'b0);
        step_free(8, 1'b1, 1'b0, 1'b0);
        step_hold(TIMEOUT_CYC, 1'b0, 1'b0);
        step_free(1, 1'b1, 1'b0, 1'b1);   // clear and set on the same edge
        step_free(1, 1'b1, 1'b1, 1'b0);
        step_free(6, 1'b1, 1'b1, 1'b0);
`else
        cur_tag = "stretch_100";
        step_free(4, 1'b1, 1'b1, 1'b0);
        step_free(4, 1'b1, 1'b0, 1'b0);
        step_hold(100, 1'b0, 1'b0);
        step_hold(2, 1'b1, 1'b0);
        step_free(8, 1'b1, 1'b1, 1'b0);
`endif

        cur_tag = "ena_drop";
        step_free(10, 1'b1, 1'b1, 1'b0);
        step_idle(2);
        step_free(3, 1'b1, 1'b1, 1'b0);

        cur_tag = "pre_rst_hold";
        step_free(1, 1'b1, 1'b1, 1'b0);
        step_free(4, 1'b1, 1'b0, 1'b0);
        step_hold(3, 1'b0, 1'b0);
        run_table();

        // Asynchronous reset in the middle of a hold takes effect at once.
        #2 rst = 1'b1;
        #1 check("rst_mid_hold", {24'd0, observed()}, {24'd0, IDLE_BITS});
        #1 rst = 1'b0;
        m_cnt = 0;
        m_to  = 1'b0;

        cur_tag = "after_rst";
        step_free(9, 1'b1, 1'b1, 1'b0);
        run_table();

        // Loopback: synchroniser latency adds two held cycles per period.
        loop_mode = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (scl_fall) begin
                ok = 1'b1;
                break;
            end
        end
        check("loop_first_fall", {31'd0, ok}, 32'd1);
        n = 0; n_str = 0; n_rise = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            n_str  += int'(stretching);
            n_rise += int'(scl_rise);
        end while (!scl_fall && n < 100);
        check("loop_period", n, 4*DIVIDER + SYNC_STAGES);
        check("loop_stretch_cycles", n_str, SYNC_STAGES);
        check("loop_scl_rise_count", n_rise, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
